// File: rtl/jt900h_ldx_ctl_pkg.sv
// Shared definitions for the TLCS-900H block-transfer sequencer:
// register-file codes, writeback strobe encodings and pointer stepping.
package jt900h_ldx_ctl_pkg;

    localparam logic [3:0] BANK_CUR = 4'hE;
    localparam logic [7:0] REG_XHL  = {BANK_CUR, 4'hC};
    localparam logic [7:0] REG_XDE  = {BANK_CUR, 4'h8};
    localparam logic [7:0] REG_BC   = {BANK_CUR, 4'h4};

    // {long, word, byte} writeback strobe, one-hot
    typedef logic [2:0] wb_strobe_t;
    localparam wb_strobe_t WB_NONE = 3'b000;
    localparam wb_strobe_t WB_WORD = 3'b010;
    localparam wb_strobe_t WB_LONG = 3'b100;

    typedef struct packed {
        logic wsize;
        logic dec;
        logic rpt;
    } ldx_mode_t;

    // Pointers step by the element size and wrap modulo 2^32
    function automatic logic [31:0] ptr_step(input logic [31:0] ptr, input ldx_mode_t mode);
        logic [31:0] step;
        step = mode.wsize ? 32'd2 : 32'd1;
        return mode.dec ? ptr - step : ptr + step;
    endfunction

endpackage

// File: rtl/jt900h_ldx_ctl_if.sv
// Memory bus and register-file writeback port of the block-transfer sequencer.
interface jt900h_ldx_ctl_if #(parameter int AW = 24);
    import jt900h_ldx_ctl_pkg::*;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_dout;
    logic [15:0]   mem_din;
    logic          mem_ack;
    logic [7:0]    wb_sel;
    logic [31:0]   wb_data;
    wb_strobe_t    wb_we;

    modport master (
        output mem_req, mem_we, mem_addr, mem_dout, wb_sel, wb_data, wb_we,
        input  mem_din, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_dout, wb_sel, wb_data, wb_we,
        output mem_din, mem_ack
    );

endinterface

// File: rtl/jt900h_ldx_ctl.sv
// LDI/LDIR/LDD/LDDR sequencer: copies (XHL)->(XDE) per iteration and writes
// the stepped XHL, XDE and decremented BC back to the register file.
module jt900h_ldx_ctl
    import jt900h_ldx_ctl_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        wsize,
    input  logic        dec,
    input  logic        rpt,
    input  logic        irq_pend,
    input  logic [31:0] xhl_in,
    input  logic [31:0] xde_in,
    input  logic [15:0] bc_in,
    jt900h_ldx_ctl_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        rewind,
    output logic        flag_v
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_WB_SRC = 3'd3;
    localparam logic [2:0] S_WB_DST = 3'd4;
    localparam logic [2:0] S_WB_CNT = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]  st;
    logic [31:0] src, dst;
    logic [15:0] cnt, data;
    ldx_mode_t   mode;
    logic        ack_q;
    logic        rewind_q;

    logic        bus_st, ack_any;
    logic [31:0] src_nxt, dst_nxt;
    logic [15:0] cnt_nxt;

    assign bus_st  = (st == S_RD) || (st == S_WR);
    assign ack_any = bus.mem_ack || ack_q;
    assign src_nxt = ptr_step(src, mode);
    assign dst_nxt = ptr_step(dst, mode);
    assign cnt_nxt = cnt - 16'd1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            data     <= '0;
            mode     <= '0;
            ack_q    <= 1'b0;
            rewind_q <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            // Read data is only valid alongside the acknowledge, so capture it even when frozen
            if (st == S_RD && bus.mem_ack && !ack_q) data <= bus.mem_din;
            if (!cen) begin
                if (bus_st && bus.mem_ack) ack_q <= 1'b1;
            end else begin
                ack_q <= 1'b0;
                case (st)
                    S_IDLE: if (start) begin
                        src      <= xhl_in;
                        dst      <= xde_in;
                        cnt      <= bc_in;
                        mode     <= {wsize, dec, rpt};
                        flag_v   <= 1'b0;
                        rewind_q <= 1'b0;
                        st       <= S_RD;
                    end
                    S_RD:     if (ack_any) st <= S_WR;
                    S_WR:     if (ack_any) st <= S_WB_SRC;
                    S_WB_SRC: begin src <= src_nxt; st <= S_WB_DST; end
                    S_WB_DST: begin dst <= dst_nxt; st <= S_WB_CNT; end
                    S_WB_CNT: begin
                        cnt      <= cnt_nxt;
                        flag_v   <= (cnt_nxt != 16'd0);
                        rewind_q <= mode.rpt && (cnt_nxt != 16'd0);
                        st       <= (mode.rpt && cnt_nxt != 16'd0 && !irq_pend) ? S_RD : S_FIN;
                    end
                    S_FIN:    st <= S_IDLE;
                    default:  st <= S_IDLE;
                endcase
            end
        end
    end

    assign busy   = (st != S_IDLE);
    assign done   = (st == S_FIN);
    assign rewind = (st == S_FIN) && rewind_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        bus.mem_req  = bus_st && !ack_q;
        bus.mem_we   = (st == S_WR);
        bus.mem_addr = (st == S_WR) ? dst[AW-1:0] : src[AW-1:0];
        bus.mem_dout = data;
        bus.wb_sel   = '0;
        bus.wb_data  = '0;
        bus.wb_we    = WB_NONE;
        case (st)
            S_WB_SRC: begin bus.wb_sel = REG_XHL; bus.wb_data = src_nxt;          bus.wb_we = WB_LONG; end
            S_WB_DST: begin bus.wb_sel = REG_XDE; bus.wb_data = dst_nxt;          bus.wb_we = WB_LONG; end
            S_WB_CNT: begin bus.wb_sel = REG_BC;  bus.wb_data = {16'h0, cnt_nxt}; bus.wb_we = WB_WORD; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jt900h_ldx_ctl.sv
// Directed self-checking bench for jt900h_ldx_ctl with a bus responder and writeback monitor.
module tb_jt900h_ldx_ctl;
    import jt900h_ldx_ctl_pkg::*;

    typedef struct packed { logic we; logic [23:0] addr; logic [15:0] data; } bus_ev_t;
    typedef struct packed { logic [7:0] sel; logic [31:0] data; logic [2:0] we; } wb_ev_t;
    typedef bus_ev_t bus_list_t[$];
    typedef wb_ev_t  wb_list_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start = 1'b0, wsize = 1'b0, dec = 1'b0, rpt = 1'b0, irq_pend = 1'b0;
    logic [31:0] xhl_in = '0, xde_in = '0;
    logic [15:0] bc_in = '0;
    logic        busy, done, rewind, flag_v;

    jt900h_ldx_ctl_if #(.AW(24)) bus_if ();

    jt900h_ldx_ctl #(.AW(24)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .wsize(wsize), .dec(dec),
        .rpt(rpt), .irq_pend(irq_pend), .xhl_in(xhl_in), .xde_in(xde_in), .bc_in(bc_in),
        .bus(bus_if), .busy(busy), .done(done), .rewind(rewind), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cen_slow  = 1'b0;
    bit rand_wait = 1'b0;
    int cen_phase = 0;
    bit counting  = 1'b0;
    int wcnt      = 0;
    bus_list_t bus_q, exp_bus;
    wb_list_t  wb_q, exp_wb;

    function automatic logic [15:0] pat(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
    endfunction

    function automatic int first_diff_bus(input bus_list_t a, input bus_list_t b);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic int first_diff_wb(input wb_list_t a, input wb_list_t b);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // Environment: clock-enable pattern, writeback monitor and memory responder
    initial begin
        bus_if.mem_ack = 1'b0;
        bus_if.mem_din = '0;
        forever begin
            @(negedge clk);
            cen_phase = (cen_phase + 1) % 3;
            cen = cen_slow ? (cen_phase == 0) : 1'b1;
            if (cen && bus_if.wb_we !== 3'b000) begin
                total++;
                if (bus_if.wb_we !== 3'b100 && bus_if.wb_we !== 3'b010) begin
                    bad++;
                    $display("FAIL wb_onehot: wb_we=%b required 100 or 010", bus_if.wb_we);
                end
                wb_q.push_back('{bus_if.wb_sel, bus_if.wb_data, bus_if.wb_we});
            end
            if (bus_if.mem_ack) begin
                bus_if.mem_ack = 1'b0;
            end else if (bus_if.mem_req === 1'b1) begin
                if (!counting) begin
                    wcnt = rand_wait ? int'($urandom_range(0, 3)) : 0;
                    counting = 1'b1;
                end
                if (wcnt == 0) begin
                    counting = 1'b0;
                    bus_if.mem_din = pat(bus_if.mem_addr);
                    bus_if.mem_ack = 1'b1;
                    bus_q.push_back('{bus_if.mem_we, bus_if.mem_addr,
                                      bus_if.mem_we ? bus_if.mem_dout : pat(bus_if.mem_addr)});
                end else begin
                    wcnt--;
                end
            end else begin
                counting = 1'b0;
            end
        end
    end

    // Reference model of one transfer: bus trace and writeback sequence
    task automatic build_expected(input logic [31:0] xhl, xde, input logic [15:0] bc,
                                  input bit ws, dc, rp, input int max_iter);
        logic [31:0] s, d, step;
        logic [15:0] c;
        int n;
        exp_bus.delete(); exp_wb.delete();
        s = xhl; d = xde; c = bc;
        step = ws ? 32'd2 : 32'd1;
        n = rp ? ((bc == 16'd0) ? 65536 : int'(bc)) : 1;
        if (max_iter > 0 && n > max_iter) n = max_iter;
        for (int i = 0; i < n; i++) begin
            exp_bus.push_back('{1'b0, s[23:0], pat(s[23:0])});
            exp_bus.push_back('{1'b1, d[23:0], pat(s[23:0])});
            s = dc ? s - step : s + step;
            d = dc ? d - step : d + step;
            c = c - 16'd1;
            exp_wb.push_back('{8'hEC, s, 3'b100});
            exp_wb.push_back('{8'hE8, d, 3'b100});
            exp_wb.push_back('{8'hE4, {16'h0, c}, 3'b010});
        end
    endtask

    task automatic run_xfer(input logic [31:0] xhl, xde, input logic [15:0] bc,
                            input bit ws, dc, rp, input int irq_at, input bit poke,
                            output bit got_done, output bit rw, output bit fv, output int dcnt);
        bit started;
        bus_q.delete(); wb_q.delete();
        got_done = 1'b0; rw = 1'b0; fv = 1'b0; dcnt = 0; started = 1'b0;
        @(negedge clk);
        xhl_in = xhl; xde_in = xde; bc_in = bc; wsize = ws; dec = dc; rpt = rp; start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin started = 1'b1; break; end
        end
        start = 1'b0;
        total++;
        if (!started) begin
            bad++;
            $display("FAIL start_accept: busy=%b required 1 within 50 cycles", busy);
            return;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (poke && cyc == 3) begin start = 1'b1; xhl_in = 32'hDEAD_0000; end
            if (poke && cyc == 4) start = 1'b0;
            if (irq_at > 0 && wb_q.size() >= irq_at) irq_pend = 1'b1;
            if (done === 1'b1) begin got_done = 1'b1; rw = rewind; fv = flag_v; break; end
            @(negedge clk);
        end
        start = 1'b0; irq_pend = 1'b0;
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL done_timeout: done=%b required 1 within 4000 cycles", done);
        end
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) dcnt++;
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_release: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; xhl_in = 32'h55; bc_in = 16'd1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, rewind, flag_v, bus_if.mem_req, bus_if.mem_we, bus_if.wb_we} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: busy/done/rewind/flag_v/req/we/wb_we=%b required all 0",
                     {busy, done, rewind, flag_v, bus_if.mem_req, bus_if.mem_we, bus_if.wb_we});
        end
        total++;
        if (bus_if.mem_addr !== 24'h0) begin
            bad++;
            $display("FAIL reset_addr: mem_addr=%h required 000000", bus_if.mem_addr);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_with_rst: busy=%b required 0", busy);
        end
    endtask

    task automatic test_ldi_byte();
        bit gd, rw, fv; int dc; int d;
        build_expected(32'h100, 32'h200, 16'd3, 1'b0, 1'b0, 1'b0, 0);
        run_xfer(32'h100, 32'h200, 16'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0, gd, rw, fv, dc);
        d = first_diff_bus(bus_q, exp_bus);
        total++;
        if (d >= 0) begin bad++; $display("FAIL ldi_bus: first diff at %0d of %0d events required %0d", d, bus_q.size(), exp_bus.size()); end
        d = first_diff_wb(wb_q, exp_wb);
        total++;
        if (d >= 0) begin bad++; $display("FAIL ldi_wb: first diff at %0d of %0d writes required %0d", d, wb_q.size(), exp_wb.size()); end
        total++;
        if (wb_q.size() != 3 || wb_q[0].data !== 32'h101 || wb_q[1].data !== 32'h201 || wb_q[2].data !== 32'h2) begin
            bad++; $display("FAIL ldi_final: %0d writes required XHL=101 XDE=201 BC=2", wb_q.size());
        end
        total++;
        if ({fv, rw, dc == 1} !== 3'b101) begin
            bad++; $display("FAIL ldi_flags: flag_v=%b rewind=%b done_cycles=%0d required 1 0 1", fv, rw, dc);
        end
    endtask

    task automatic test_ldir_word();
        bit gd, rw, fv; int dc; int d;
        build_expected(32'h1000, 32'h2000, 16'd4, 1'b1, 1'b0, 1'b1, 0);
        run_xfer(32'h1000, 32'h2000, 16'd4, 1'b1, 1'b0, 1'b1, 0, 1'b1, gd, rw, fv, dc);
        d = first_diff_bus(bus_q, exp_bus);
        total++;
        if (d >= 0) begin bad++; $display("FAIL ldir_bus: first diff at %0d of %0d events required %0d", d, bus_q.size(), exp_bus.size()); end
        d = first_diff_wb(wb_q, exp_wb);
        total++;
        if (d >= 0) begin bad++; $display("FAIL ldir_wb: first diff at %0d of %0d writes required %0d", d, wb_q.size(), exp_wb.size()); end
        total++;
        if (wb_q.size() != 12 || wb_q[9].data !== 32'h1008 || wb_q[10].data !== 32'h2008 || wb_q[11].data !== 32'h0) begin
            bad++; $display("FAIL ldir_final: %0d writes required 12 ending XHL=1008 XDE=2008 BC=0", wb_q.size());
        end
        total++;
        if ({fv, rw} !== 2'b00) begin
            bad++; $display("FAIL ldir_flags: flag_v=%b rewind=%b required 0 0", fv, rw);
        end
    endtask

    task automatic test_lddr_wrap();
        bit gd, rw, fv; int dc; int d;
        build_expected(32'h0, 32'h500, 16'd2, 1'b0, 1'b1, 1'b1, 0);
        run_xfer(32'h0, 32'h500, 16'd2, 1'b0, 1'b1, 1'b1, 0, 1'b0, gd, rw, fv, dc);
        d = first_diff_bus(bus_q, exp_bus);
        total++;
        if (d >= 0) begin bad++; $display("FAIL lddr_bus: first diff at %0d of %0d events required %0d", d, bus_q.size(), exp_bus.size()); end
        total++;
        if (bus_q.size() != 4 || bus_q[0].addr !== 24'h0 || bus_q[2].addr !== 24'hFFFFFF) begin
            bad++; $display("FAIL lddr_addr: %0d events required reads at 000000 then FFFFFF", bus_q.size());
        end
        total++;
        if (wb_q.size() != 6 || wb_q[3].data !== 32'hFFFF_FFFE || wb_q[5].data !== 32'h0) begin
            bad++; $display("FAIL lddr_final: %0d writes required XHL=FFFFFFFE BC=0", wb_q.size());
        end
    endtask

    task automatic test_irq_stop();
        bit gd, rw, fv; int dc; int d;
        build_expected(32'h300, 32'h400, 16'd5, 1'b0, 1'b0, 1'b1, 2);
        run_xfer(32'h300, 32'h400, 16'd5, 1'b0, 1'b0, 1'b1, 4, 1'b0, gd, rw, fv, dc);
        d = first_diff_wb(wb_q, exp_wb);
        total++;
        if (d >= 0) begin bad++; $display("FAIL irq_wb: first diff at %0d of %0d writes required %0d", d, wb_q.size(), exp_wb.size()); end
        total++;
        if (wb_q.size() != 6 || wb_q[5].data !== 32'h3 || bus_q.size() != 4) begin
            bad++; $display("FAIL irq_count: %0d writes %0d bus events required 6, 4, BC=3", wb_q.size(), bus_q.size());
        end
        total++;
        if ({fv, rw} !== 2'b11) begin
            bad++; $display("FAIL irq_flags: flag_v=%b rewind=%b required 1 1", fv, rw);
        end
    endtask

    task automatic test_cen_waits();
        bit gd, rw, fv; int dc; int d;
        bus_list_t fast_bus;
        wb_list_t  fast_wb;
        build_expected(32'h8000, 32'h9000, 16'd3, 1'b1, 1'b0, 1'b1, 0);
        run_xfer(32'h8000, 32'h9000, 16'd3, 1'b1, 1'b0, 1'b1, 0, 1'b0, gd, rw, fv, dc);
        fast_bus = bus_q; fast_wb = wb_q;
        d = first_diff_bus(fast_bus, exp_bus);
        total++;
        if (d >= 0) begin bad++; $display("FAIL cen_fast_bus: first diff at %0d of %0d required %0d", d, fast_bus.size(), exp_bus.size()); end
        cen_slow = 1'b1; rand_wait = 1'b1;
        run_xfer(32'h8000, 32'h9000, 16'd3, 1'b1, 1'b0, 1'b1, 0, 1'b0, gd, rw, fv, dc);
        cen_slow = 1'b0; rand_wait = 1'b0;
        d = first_diff_bus(bus_q, exp_bus);
        total++;
        if (d >= 0) begin bad++; $display("FAIL cen_slow_bus: first diff at %0d of %0d required %0d", d, bus_q.size(), exp_bus.size()); end
        d = first_diff_wb(wb_q, fast_wb);
        total++;
        if (d >= 0) begin bad++; $display("FAIL cen_slow_wb: first diff at %0d of %0d required %0d", d, wb_q.size(), fast_wb.size()); end
        total++;
        if ({fv, rw} !== 2'b00) begin
            bad++; $display("FAIL cen_slow_flags: flag_v=%b rewind=%b required 0 0", fv, rw);
        end
    endtask

    task automatic test_rst_mid();
        bit found;
        int n;
        found = 1'b0;
        bus_q.delete(); wb_q.delete();
        @(negedge clk);
        xhl_in = 32'h600; xde_in = 32'h700; bc_in = 16'd4; wsize = 1'b0; dec = 1'b0; rpt = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.mem_we === 1'b1 && bus_if.mem_req === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_reach_wr: mem_we=%b required 1 within 100 cycles", bus_if.mem_we); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, bus_if.mem_req, done, bus_if.wb_we} !== 6'b0) begin
            bad++; $display("FAIL rst_mid_idle: busy/req/done/wb_we=%b required all 0", {busy, bus_if.mem_req, done, bus_if.wb_we});
        end
        rst = 1'b0;
        n = wb_q.size();
        repeat (10) @(negedge clk);
        total++;
        if (wb_q.size() != n || busy !== 1'b0) begin
            bad++; $display("FAIL rst_no_wb: writes after reset=%0d busy=%b required 0 0", wb_q.size() - n, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_byte();
        test_ldir_word();
        test_lddr_wrap();
        test_irq_stop();
        test_cen_waits();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
